seq_divider: RTL and testbench

- Sequential signed restoring divider; the inverse datapath companion to the team's Booth multiplier.
- Computes quotient and remainder of WIDTH-bit two's-complement operands at one quotient bit per cycle.
- Uses a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic unit; results are held until the next accepted start.

---
 rtl/div_pkg.sv | 12 +
 rtl/seq_divider_if.sv | 27 ++
 rtl/div_restore_step.sv | 25 ++
 rtl/seq_divider.sv | 142 ++++++++++++++
 tb/tb_seq_divider.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: default width and FSM encoding.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_restore_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dvs_mag,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // dvs_mag never exceeds 2^(WIDTH-1), so a negative trial difference always sets the top bit.
    always_comb begin
        rem_sh  = {rem_in, dvd_bit};
        diff    = rem_sh - {1'b0, dvs_mag};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider, one quotient bit per cycle, results held until the next start.
//
// state     | meaning
// ST_IDLE   | waiting for start; outputs hold the last result
// ST_RUN    | WIDTH shift/subtract steps, MSB of the dividend first
// ST_FINISH | apply signs, register results, pulse done on the way to IDLE
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs_mag;
    logic             sign_q;
    logic             sign_r;
    logic             dz;

    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             div_by_zero_r;
    logic             done_r;

    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH-1:0] rem_nxt;
    logic             q_bit;
    logic             start_ok;
    logic             divisor_zero;
    logic             last_step;

    always_comb begin
        dvd_abs      = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        dvs_abs      = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
        divisor_zero = (bus.divisor == '0);
        start_ok     = bus.start && (state == ST_IDLE);
        last_step    = (count == CW'(WIDTH - 1));
    end

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .dvd_bit (acc[WIDTH-1]),
        .dvs_mag (dvs_mag),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = divisor_zero ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_step) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (state != ST_IDLE);
        bus.done        = done_r;
        bus.quotient    = quotient_r;
        bus.remainder   = remainder_r;
        bus.div_by_zero = div_by_zero_r;
    end

    // acc starts as |dividend| and shifts left each step, so it ends up holding |quotient|.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count         <= '0;
            acc           <= '0;
            rem           <= '0;
            dvs_mag       <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            dz            <= 1'b0;
            quotient_r    <= '0;
            remainder_r   <= '0;
            div_by_zero_r <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        sign_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        sign_r  <= bus.dividend[WIDTH-1];
                        acc     <= dvd_abs;
                        dvs_mag <= dvs_abs;
                        rem     <= '0;
                        count   <= '0;
                        dz      <= divisor_zero;
                    end
                end
                ST_RUN: begin
                    acc   <= {acc[WIDTH-2:0], q_bit};
                    rem   <= rem_nxt;
                    count <= count + CW'(1);
                end
                ST_FINISH: begin
                    done_r        <= 1'b1;
                    div_by_zero_r <= dz;
                    if (dz) begin
                        // acc was never shifted, so it still holds |dividend|.
                        quotient_r  <= '1;
                        remainder_r <= sign_r ? -acc : acc;
                    end else begin
                        quotient_r  <= sign_q ? -acc : acc;
                        remainder_r <= sign_r ? -rem : rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider with a queue-based result scoreboard.
module tb_seq_divider;

    localparam int W      = 32;
    localparam int LAT    = W + 1;
    localparam int LAT_DZ = 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   tests;
    int   fails;
    exp_t sb[$];

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result, including its cycle.
    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no result", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient",    bus.quotient,  e.q);
                chk("remainder",   bus.remainder, e.r);
                chk("div_by_zero", W'(bus.div_by_zero), W'(e.dz));
                chk("done_cycle",  W'(cyc), W'(e.cyc));
            end
        end
    end

    // Drive start for one edge and queue the result it should produce.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input int lat);
        exp_t e;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        e.q   = eq;
        e.r   = er;
        e.dz  = edz;
        e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) break;
        end
        if (bus.done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected a done pulse", budget);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input int lat);
        issue(a, b, eq, er, edz, lat);
        wait_done(lat + 5);
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        #12;
        chk("reset_quotient",  bus.quotient,  '0);
        chk("reset_remainder", bus.remainder, '0);
        chk("reset_busy",      W'(bus.busy),  '0);
        chk("reset_done",      W'(bus.done),  '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT);
        @(negedge clk);
        chk("busy_after_done", W'(bus.busy), '0);
        chk("done_single",     W'(bus.done), '0);
        chk("held_quotient",   bus.quotient, 32'd14);

        run_op(-32'sd100,  32'sd7,  -32'sd14, -32'sd2, 1'b0, LAT);
        run_op( 32'sd100, -32'sd7,  -32'sd14,  32'sd2, 1'b0, LAT);
        run_op(-32'sd100, -32'sd7,   32'sd14, -32'sd2, 1'b0, LAT);
        run_op(32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, LAT_DZ);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, LAT);
        run_op(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, LAT);
        run_op(32'd7, 32'd100, 32'd0, 32'd7, 1'b0, LAT);
        run_op(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, LAT);

        // start while busy must be ignored; then restart on the done cycle itself
        @(negedge clk);
        issue(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, LAT);
        repeat (9) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(LAT + 5);
        run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LAT);

        // asynchronous reset mid-operation: outputs clear at once, no done follows
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #4;
        reset = 1'b1;
        #1;
        chk("async_rst_quotient",  bus.quotient,  '0);
        chk("async_rst_remainder", bus.remainder, '0);
        chk("async_rst_busy",      W'(bus.busy),  '0);
        chk("async_rst_done",      W'(bus.done),  '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        run_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, LAT);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", W'(sb.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
